// File: rtl/mdr_request_arbiter_pkg.sv
// Shared definitions for the mdr_request_arbiter block.
//   arb_state_t : arbiter FSM states
//   OPC_*       : datapath opcodes (OPC_NOP is never a legal request)
//   CeilLog2    : index width helper, never returns less than 1
package mdr_request_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        ABORT,
        RESP
    } arb_state_t;

    localparam logic [1:0] OPC_DIV  = 2'b00;
    localparam logic [1:0] OPC_SQRT = 2'b01;
    localparam logic [1:0] OPC_MULT = 2'b10;
    localparam logic [1:0] OPC_NOP  = 2'b11;

    function automatic int unsigned CeilLog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/mdr_request_arbiter_rr_priority_encoder.sv
// Combinational round-robin search.
//   req     : pending request vector
//   pointer : index of the last granted requester
//   winner  : first set req bit at or after pointer+1, wrapping modulo N_REQ
//   valid   : at least one request pending
module mdr_request_arbiter_rr_priority_encoder
    import mdr_request_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = CeilLog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    int unsigned      pos;
    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        pos    = 0;
        idx    = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            pos = (32'(pointer) + off) % N_REQ;
            idx = IDX_W'(pos);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mdr_request_arbiter.sv
// Shares one multiply/divide/sqrt datapath between N_REQ requesters.
//   req/req_opc/req_x/req_y : per-requester request, opcode and operands
//   gnt, resp_valid         : one-hot single-cycle grant and response strobes
//   resp_result/remainder   : response payload, held until the next response
//   resp_error              : timeout or illegal opcode, qualifies resp_valid
//   dp_*                    : datapath start/abort, latched opcode/operands, completion
//   busy                    : high whenever the FSM is not idle
module mdr_request_arbiter
    import mdr_request_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LENGHT    = 4,
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [2*N_REQ-1:0]         req_opc,
    input  logic [WORD_LENGHT*N_REQ-1:0] req_x,
    input  logic [WORD_LENGHT*N_REQ-1:0] req_y,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           resp_valid,
    output logic [2*WORD_LENGHT-1:0]   resp_result,
    output logic [WORD_LENGHT-1:0]     resp_remainder,
    output logic                       resp_error,
    output logic                       dp_start,
    output logic                       dp_sync_rst,
    output logic [1:0]                 dp_opc,
    output logic [WORD_LENGHT-1:0]     dp_x,
    output logic [WORD_LENGHT-1:0]     dp_y,
    input  logic                       dp_ready,
    input  logic [2*WORD_LENGHT-1:0]   dp_result,
    input  logic [WORD_LENGHT-1:0]     dp_remainder,
    output logic                       busy
);

    localparam int unsigned IDX_W = CeilLog2(N_REQ);
    localparam int unsigned CNT_W = CeilLog2(TIMEOUT_CYCLES);
    // Abort is taken when the incremented count would reach TIMEOUT_CYCLES-1,
    // which places dp_sync_rst exactly TIMEOUT_CYCLES cycles after dp_start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    arb_state_t                 state_q, state_d;
    logic [IDX_W-1:0]           winner_q, winner_d;
    logic [IDX_W-1:0]           pointer_q, pointer_d;
    logic [1:0]                 opc_q, opc_d;
    logic [WORD_LENGHT-1:0]     x_q, x_d;
    logic [WORD_LENGHT-1:0]     y_q, y_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [2*WORD_LENGHT-1:0]   result_q, result_d;
    logic [WORD_LENGHT-1:0]     rem_q, rem_d;
    logic                       err_q, err_d;

    logic [IDX_W-1:0]           arb_winner;
    logic                       arb_valid;

    mdr_request_arbiter_rr_priority_encoder #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_priority_encoder (
        .req     (req),
        .pointer (pointer_q),
        .winner  (arb_winner),
        .valid   (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        pointer_d   = pointer_q;
        opc_d       = opc_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        rem_d       = rem_q;
        err_d       = err_q;
        gnt         = '0;
        resp_valid  = '0;
        dp_start    = 1'b0;
        dp_sync_rst = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    winner_d = arb_winner;
                    opc_d    = req_opc[2*arb_winner +: 2];
                    x_d      = req_x[WORD_LENGHT*arb_winner +: WORD_LENGHT];
                    y_d      = req_y[WORD_LENGHT*arb_winner +: WORD_LENGHT];
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                gnt[winner_q] = 1'b1;
                if (opc_q == OPC_NOP) begin
                    result_d = '0;
                    rem_d    = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    state_d  = START;
                end
            end
            START: begin
                dp_start = 1'b1;
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                // A completion on the terminal-count cycle still wins over abort.
                if (dp_ready) begin
                    result_d = dp_result;
                    rem_d    = (opc_q == OPC_MULT) ? '0 : dp_remainder;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ABORT;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ABORT: begin
                dp_sync_rst = 1'b1;
                result_d    = '0;
                rem_d       = '0;
                err_d       = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                resp_valid[winner_q] = 1'b1;
                pointer_d            = winner_q;
                state_d              = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            pointer_q <= IDX_W'(N_REQ - 1);
            opc_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            pointer_q <= pointer_d;
            opc_q     <= opc_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
        end
    end

    assign dp_opc         = opc_q;
    assign dp_x           = x_q;
    assign dp_y           = y_q;
    assign resp_result    = result_q;
    assign resp_remainder = rem_q;
    assign resp_error     = err_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: doc/mdr_request_arbiter.md
Name: mdr_request_arbiter

Overview:
- Shares one multiply/divide/sqrt datapath (ROM-sequenced control plus arithmetic) between N_REQ independent requesters.
- Picks one pending request round-robin, loads its opcode and operands, pulses the datapath start, and waits for completion with a timeout watchdog.
- Returns the result to the winning requester.
- Sits between the requesting blocks and the datapath top level.

Parameters:
WORD_LENGHT, 4, operand width in bits
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 32, max cycles waiting for dp_ready before abort

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
req  input  N_REQ  request per requester, held until its resp_valid
req_opc  input  2*N_REQ  opcode per requester, slice i = [2i+1:2i]
req_x  input  WORD_LENGHT*N_REQ  operand X per requester
req_y  input  WORD_LENGHT*N_REQ  operand Y per requester
gnt  output  N_REQ  one-hot grant, 1-cycle pulse
resp_valid  output  N_REQ  one-hot response strobe, 1-cycle pulse
resp_result  output  2*WORD_LENGHT  product/quotient/root (zero-extended)
resp_remainder  output  WORD_LENGHT  remainder (div/sqrt), 0 for mult
resp_error  output  1  qualifies resp_valid: timeout or illegal opcode
dp_start  output  1  datapath start pulse
dp_sync_rst  output  1  datapath synchronous abort
dp_opc  output  2  latched opcode to datapath
dp_x, dp_y  output  WORD_LENGHT each  latched operands
dp_ready  input  1  datapath done, 1-cycle pulse
dp_result  input  2*WORD_LENGHT  datapath result
dp_remainder  input  WORD_LENGHT  datapath remainder
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; latched opcode/operands 0; last-grant pointer = N_REQ-1, so req[0] has highest priority first. Timeout counter 0.
- Opcodes: OPC_DIV=2'b00, OPC_SQRT=2'b01, OPC_MULT=2'b10, OPC_NOP=2'b11 (illegal as a request).
- FSM states and transitions:
  - IDLE: if |req, register the winner index, its opcode and operands → GRANT.
  - GRANT: gnt[winner]=1. If opcode=OPC_NOP → RESP with error; else → START.
  - START: dp_start=1 one cycle; timeout counter cleared → WAIT.
  - WAIT: counter increments each cycle. If dp_ready → capture dp_result/dp_remainder → RESP. If counter reaches TIMEOUT_CYCLES-1 without dp_ready → ABORT. dp_ready in the same cycle as the terminal count wins: no abort.
  - ABORT: dp_sync_rst=1 one cycle → RESP with error.
  - RESP: resp_valid[winner]=1 one cycle. resp_result/resp_remainder = captured values; on error both are 0 and resp_error=1. Pointer ← winner → IDLE.
- Arbitration: search starts at pointer+1 and wraps modulo N_REQ; the first set req bit wins. Arbitration happens only in IDLE.
- Latency: req seen at edge 0 → gnt cycle 1 → dp_start cycle 2 → dp_ready cycle k → resp_valid cycle k+1. Minimum request-to-response is 4 cycles (dp_ready at cycle 3). Back-to-back grants are separated by at least one IDLE cycle.
- Holding requirements:
  - dp_opc, dp_x and dp_y hold stable from START until leaving WAIT/ABORT.
  - resp_result/resp_remainder/resp_error hold until the next RESP.
- Requests and spurious datapath pulses:
  - A req dropped after gnt is ignored; the operation completes and resp_valid is still issued.
  - req changes on other channels have no effect while busy.
  - dp_ready outside WAIT is ignored.
- Mid-operation reset: rst low in any state returns immediately to IDLE and clears outputs; no response is issued.

Decomposition:
- Package Definitions gains:
  - enum ARB_STATE_T {IDLE, GRANT, START, WAIT, ABORT, RESP};
  - OPC_* localparams;
  - CeilLog2 function, shared (not duplicated locally).
- One sub-module: rr_priority_encoder (N_REQ, req, pointer → winner index, valid). It is combinational round-robin search and is separately testable.

Test Plan:
- Single request: req=4'b0001, opc=OPC_MULT, x=4'd7, y=4'd5, datapath model drives dp_ready 10 cycles after dp_start with result 35 → gnt[0]@1, dp_start@2, resp_valid=4'b0001 with result 8'd35, remainder 0, error 0.
- Round-robin fairness: req=4'b1111 held continuously → grant order 0,1,2,3,0; each gnt one-hot and one cycle wide.
- Division: req[2], OPC_DIV, x=13, y=4, dp_result=3, dp_remainder=1 → resp_valid[2], result 8'd3, remainder 4'd1; dp_x=13 and dp_y=4 stable throughout WAIT.
- Timeout: datapath never asserts dp_ready → dp_sync_rst pulse exactly TIMEOUT_CYCLES cycles after dp_start; then resp_valid with error=1 and result 0.
- Illegal opcode: req[1], OPC_NOP → gnt[1], no dp_start, resp_valid[1] with error=1 the following cycle.
- Reset mid-WAIT: rst low for 1 cycle during WAIT → busy=0 and all outputs 0 asynchronously; no resp_valid; the next request is granted to req[0] first.
